// File: rtl/dual_issue_scoreboard.sv
// Central dual-issue scoreboard: per-register latency countdowns decide each cycle
// whether the even slot, the odd slot, both or neither issue, in program order.
module dual_issue_scoreboard #(
    parameter int unsigned NREG  = 128,
    parameter int unsigned LAT_W = 3,
    localparam int unsigned RW   = $clog2(NREG),
    localparam int unsigned PW   = $clog2(NREG + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_valid,
    input  logic             ev_wr,
    input  logic [RW-1:0]    ev_rt,
    input  logic [LAT_W-1:0] ev_lat,
    input  logic [3*RW-1:0]  ev_src,
    input  logic [2:0]       ev_src_v,
    input  logic             od_valid,
    input  logic             od_wr,
    input  logic [RW-1:0]    od_rt,
    input  logic [LAT_W-1:0] od_lat,
    input  logic [3*RW-1:0]  od_src,
    input  logic [2:0]       od_src_v,
    input  logic             flush,
    output logic             ev_issue,
    output logic             od_issue,
    output logic [PW-1:0]    pending_cnt
);

    logic [LAT_W-1:0] cnt     [NREG];
    logic [LAT_W-1:0] cnt_nxt [NREG];
    logic [PW-1:0]    pend_nxt;

    logic ev_busy, od_busy, ev_waw, od_waw, pair_haz, ev_ok, od_ok;

    // Hazard evaluation against the current countdowns and the older even slot.
    always_comb begin
        ev_busy  = 1'b0;
        od_busy  = 1'b0;
        pair_haz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ev_src_v[i] && (cnt[ev_src[i*RW +: RW]] != '0))
                ev_busy = 1'b1;
            if (od_src_v[i] && (cnt[od_src[i*RW +: RW]] != '0))
                od_busy = 1'b1;
            if (ev_valid && ev_wr && od_src_v[i] && (od_src[i*RW +: RW] == ev_rt))
                pair_haz = 1'b1;
        end
        if (ev_valid && ev_wr && od_wr && (od_rt == ev_rt))
            pair_haz = 1'b1;

        ev_waw = ev_wr && (cnt[ev_rt] > ev_lat);
        od_waw = od_wr && (cnt[od_rt] > od_lat);

        ev_ok = ev_valid && !flush && !ev_busy && !ev_waw;
        od_ok = od_valid && !flush && !od_busy && !od_waw && !pair_haz;

        ev_issue = !reset && ev_ok;
        od_issue = !reset && od_ok && (ev_ok || !ev_valid);
    end

    // Countdown update: decrement everything, then newly issued writes override.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt[RW'(r)] = (cnt[RW'(r)] != '0) ? cnt[RW'(r)] - LAT_W'(1) : '0;
        end
        if (ev_issue && ev_wr)
            cnt_nxt[ev_rt] = (ev_lat == '0) ? LAT_W'(1) : ev_lat;
        if (od_issue && od_wr)
            cnt_nxt[od_rt] = (od_lat == '0) ? LAT_W'(1) : od_lat;

        pend_nxt = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_nxt = pend_nxt + PW'(cnt_nxt[RW'(r)] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[RW'(r)] <= '0;
            end
            pending_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[RW'(r)] <= cnt_nxt[RW'(r)];
            end
            pending_cnt <= pend_nxt;
        end
    end

endmodule
